// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the shared UART transmitter: per-requester byte
// handshakes plus the arbiter's status and the serial line itself.
interface uart_tx_arbiter_if #(
   parameter int NumReq = 2
);
   logic [NumReq-1:0]         req_valid_i;
   logic [NumReq*8-1:0]       req_data_i;
   logic [NumReq-1:0]         req_lock_i;
   logic [NumReq-1:0]         req_ready_o;
   logic [$clog2(NumReq)-1:0] grant_o;
   logic                      busy_o;
   logic                      uart_tx_o;

   modport slave (
      input  req_valid_i, req_data_i, req_lock_i,
      output req_ready_o, grant_o, busy_o, uart_tx_o
   );

   modport master (
      output req_valid_i, req_data_i, req_lock_i,
      input  req_ready_o, grant_o, busy_o, uart_tx_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-requester lock feeding a single 8N1 UART
// transmitter; one byte is accepted per frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, arbitrating; ready offered to the chosen requester
// ST_START | start bit (low) for ClksPerBit cycles
// ST_DATA  | 8 data bits, LSB first, ClksPerBit cycles each
// ST_STOP  | stop bit (high); lock request sampled on its last cycle
module uart_tx_arbiter #(
   parameter int NumReq         = 2,
   parameter int ClockFrequency = 25_000_000,
   parameter int BaudRate       = 115_200
) (
   input logic              clk_i,
   input logic              rst_ni,
   uart_tx_arbiter_if.slave bus
);
   localparam int ClksPerBit = ClockFrequency / BaudRate;
   localparam int GrantW     = $clog2(NumReq);
   localparam int BaudW      = $clog2(ClksPerBit);
   localparam logic [BaudW-1:0]  BaudLast = BaudW'(ClksPerBit - 1);
   localparam logic [GrantW-1:0] LastReq  = GrantW'(NumReq - 1);

   if (ClksPerBit < 2) begin : g_bad_baud
      $error("uart_tx_arbiter: ClksPerBit must be at least 2");
   end
   if (NumReq < 2) begin : g_bad_numreq
      $error("uart_tx_arbiter: NumReq must be at least 2");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   state_t            state_q;
   logic [BaudW-1:0]  baud_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              tx_q;
   logic              busy_q;
   logic              locked_q;
   logic [GrantW-1:0] grant_q;
   logic [GrantW-1:0] rr_q;

   logic              lock_hold;
   logic              pick_found;
   logic [GrantW-1:0] pick_idx;
   logic [GrantW-1:0] scan_idx;
   int                scan_sum;
   logic [NumReq-1:0] ready_d;
   logic [7:0]        pick_data;
   logic              handshake;
   logic [GrantW-1:0] rr_next;

   // A held lock is released the moment its owner drops req_lock, so the
   // other requesters can win in that very cycle.
   assign lock_hold = locked_q & bus.req_lock_i[grant_q];

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_q;
      scan_idx   = rr_q;
      scan_sum   = 0;
      if (lock_hold) begin
         pick_found = bus.req_valid_i[grant_q];
         pick_idx   = grant_q;
      end else begin
         for (int k = 0; k < NumReq; k++) begin
            scan_sum = int'(rr_q) + k;
            if (scan_sum >= NumReq) scan_sum = scan_sum - NumReq;
            scan_idx = GrantW'(scan_sum);
            if (!pick_found && bus.req_valid_i[scan_idx]) begin
               pick_found = 1'b1;
               pick_idx   = scan_idx;
            end
         end
      end
   end

   always_comb begin
      ready_d = '0;
      if (state_q == ST_IDLE && pick_found) ready_d[pick_idx] = 1'b1;
   end

   assign handshake = (state_q == ST_IDLE) && pick_found;
   assign pick_data = bus.req_data_i[8*pick_idx +: 8];
   assign rr_next   = (pick_idx == LastReq) ? '0 : pick_idx + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
         grant_q  <= '0;
         rr_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               locked_q <= lock_hold;
               if (handshake) begin
                  shift_q <= pick_data;
                  grant_q <= pick_idx;
                  rr_q    <= rr_next;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  baud_q  <= BaudLast;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (baud_q == '0) begin
                  tx_q    <= shift_q[0];
                  shift_q <= {1'b0, shift_q[7:1]};
                  bit_q   <= 3'd7;
                  baud_q  <= BaudLast;
                  state_q <= ST_DATA;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_q == '0) begin
                  baud_q <= BaudLast;
                  if (bit_q == 3'd0) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[7:1]};
                     bit_q   <= bit_q - 1'b1;
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_q == '0) begin
                  locked_q <= bus.req_lock_i[grant_q];
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o = ready_d;
   assign bus.grant_o     = grant_q;
   assign bus.busy_o      = busy_q;
   assign bus.uart_tx_o   = tx_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scripted and random requester traffic, an
// arbitration reference model, and a serial-line monitor scoreboard.
module tb_uart_tx_arbiter;
   localparam int NumReq   = 2;
   localparam int ClkFreq  = 1_000_000;
   localparam int Baud     = 250_000;
   localparam int Cpb      = 4;
   localparam int FrameCyc = 10 * Cpb;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NumReq(NumReq)) bus ();

   uart_tx_arbiter #(
      .NumReq        (NumReq),
      .ClockFrequency(ClkFreq),
      .BaudRate      (Baud)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   logic [1:0]  valid_v = '0;
   logic [1:0]  lock_v  = '0;
   logic [15:0] data_v  = '0;
   assign bus.req_valid_i = valid_v;
   assign bus.req_lock_i  = lock_v;
   assign bus.req_data_i  = data_v;

   typedef struct {
      logic [7:0] data;
      logic       lock;
      int         gap;
      bit         nobyte;
   } item_t;

   item_t src0_q[$];
   item_t src1_q[$];
   item_t cur[2];
   bit    have[2];
   int    gap_left[2];
   bit    noise_en = 1'b0;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   logic [7:0] exp_q[$];
   int         log_req[$];
   logic [7:0] log_dat[$];
   int         log_cyc[$];

   int m_cnt    = 0;
   bit m_locked = 1'b0;
   int m_rr     = 0;
   int m_grant  = 0;

   bit         mon_active = 1'b0;
   int         mon_k      = 0;
   bit         mon_err    = 1'b0;
   logic [9:0] mon_frame  = '0;
   logic [9:0] mon_bits   = '0;
   logic [7:0] mon_exp    = '0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic item_t mk(input logic [7:0] d, input logic l, input int g, input bit nb);
      item_t it;
      it.data   = d;
      it.lock   = l;
      it.gap    = g;
      it.nobyte = nb;
      return it;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Requester drivers: one process owns every requester-side input.
   task automatic drive_step(input int i, input logic hs);
      if (i == 0 && noise_en) begin
         valid_v[0]  = 1'($urandom_range(0, 1));
         data_v[7:0] = 8'($urandom);
         lock_v[0]   = 1'b0;
         have[0]     = 1'b0;
         return;
      end
      if (hs && have[i] && valid_v[i]) begin
         lock_v[i]  = cur[i].lock;
         valid_v[i] = 1'b0;
         have[i]    = 1'b0;
      end
      if (!have[i]) valid_v[i] = 1'b0;
      if (!have[i]) begin
         if (i == 0 && src0_q.size() > 0) begin
            cur[0] = src0_q.pop_front(); have[0] = 1'b1; gap_left[0] = cur[0].gap;
         end else if (i == 1 && src1_q.size() > 0) begin
            cur[1] = src1_q.pop_front(); have[1] = 1'b1; gap_left[1] = cur[1].gap;
         end
      end
      if (have[i] && !valid_v[i]) begin
         if (gap_left[i] > 0) begin
            gap_left[i]--;
         end else if (cur[i].nobyte) begin
            lock_v[i] = cur[i].lock;
            have[i]   = 1'b0;
         end else begin
            valid_v[i]         = 1'b1;
            data_v[8*i +: 8]   = cur[i].data;
         end
      end
   endtask

   initial begin : driver
      logic [1:0] hs_d;
      have[0] = 1'b0; have[1] = 1'b0;
      gap_left[0] = 0; gap_left[1] = 0;
      forever begin
         @(negedge clk);
         hs_d = bus.req_ready_o & valid_v;
         @(posedge clk);
         #1;
         drive_step(0, hs_d[0]);
         drive_step(1, hs_d[1]);
      end
   end

   // Reference model: who should be offered ready this cycle, and frame timing.
   always @(negedge clk) begin : model
      int         c;
      bit         hold;
      logic [1:0] exp_rdy;
      if (!rst_n) begin
         m_cnt    = 0;
         m_locked = 1'b0;
         m_rr     = 0;
         m_grant  = 0;
         exp_q.delete();
      end else if (m_cnt > 0) begin
         chk("busy_in_frame", bus.busy_o, 1);
         chk("ready_in_frame", bus.req_ready_o, 0);
         if (m_cnt == FrameCyc) chk("start_latency", bus.uart_tx_o, 0);
         if (m_cnt == 1) m_locked = lock_v[m_grant];
         m_cnt--;
      end else begin
         hold     = m_locked && lock_v[m_grant];
         m_locked = hold;
         c        = -1;
         if (hold) begin
            if (valid_v[m_grant]) c = m_grant;
         end else begin
            for (int k = 0; k < NumReq; k++) begin
               if (c < 0 && valid_v[(m_rr + k) % NumReq]) c = (m_rr + k) % NumReq;
            end
         end
         exp_rdy = '0;
         if (c >= 0) exp_rdy[c] = 1'b1;
         chk("idle_busy", bus.busy_o, 0);
         chk("idle_line", bus.uart_tx_o, 1);
         chk("idle_grant", bus.grant_o, m_grant);
         chk("ready", bus.req_ready_o, exp_rdy);
         if (c >= 0) begin
            exp_q.push_back(data_v[8*c +: 8]);
            log_req.push_back(c);
            log_dat.push_back(data_v[8*c +: 8]);
            log_cyc.push_back(cyc);
            m_grant = c;
            m_rr    = (c + 1) % NumReq;
            m_cnt   = FrameCyc;
         end
      end
   end

   // Line monitor: every cycle of each frame must match the expected 8N1 shape.
   always @(negedge clk) begin : monitor
      if (!rst_n) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && bus.uart_tx_o == 1'b0) begin
            mon_active = 1'b1;
            mon_k      = 0;
            mon_err    = 1'b0;
            if (exp_q.size() > 0) begin
               mon_exp = exp_q.pop_front();
            end else begin
               mon_exp = 8'h00;
               mon_err = 1'b1;
            end
            mon_frame = {1'b1, mon_exp, 1'b0};
         end
         if (mon_active) begin
            if (bus.uart_tx_o !== mon_frame[mon_k / Cpb]) mon_err = 1'b1;
            if (mon_k % Cpb == Cpb / 2) mon_bits[mon_k / Cpb] = bus.uart_tx_o;
            mon_k++;
            if (mon_k == FrameCyc) begin
               chk("frame", {23'd0, mon_err, mon_bits[8:1]}, {24'd0, mon_exp});
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n    = 0;
      bit done = 1'b0;
      while (!done && n < budget) begin
         @(posedge clk);
         #2;
         n++;
         done = src0_q.size() == 0 && src1_q.size() == 0 && !have[0] && !have[1] &&
                valid_v == 2'b00 && m_cnt == 0 && exp_q.size() == 0 && !mon_active;
      end
      chk(name, done, 1);
   endtask

   task automatic wait_hs(input string name, input int n0, input int budget);
      int n = 0;
      while (log_req.size() <= n0 && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk(name, log_req.size() > n0, 1);
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog actual=running required=finished");
      $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int base;
      int nbytes;
      int len;
      item_t it;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", bus.uart_tx_o, 1);
      chk("rst_ready", bus.req_ready_o, 0);
      chk("rst_grant", bus.grant_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // single byte
      base = log_req.size();
      src0_q.push_back(mk(8'h55, 1'b0, 0, 1'b0));
      wait_drain("drain_single", 500);
      chk("single_count", log_req.size(), base + 1);
      if (log_req.size() > base) begin
         chk("single_req", log_req[base], 0);
         chk("single_data", log_dat[base], 8'h55);
      end

      // round-robin with both continuously valid
      base = log_req.size();
      for (int n = 0; n < 4; n++) begin
         src0_q.push_back(mk(8'($urandom), 1'b0, 0, 1'b0));
         src1_q.push_back(mk(8'($urandom), 1'b0, 0, 1'b0));
      end
      wait_drain("drain_rr", 2000);
      chk("rr_count", log_req.size(), base + 8);
      len = log_req.size();
      for (int i = base + 1; i < len; i++) begin
         chk("rr_alternate", log_req[i], 1 - log_req[i-1]);
         chk("rr_spacing", log_cyc[i] - log_cyc[i-1], FrameCyc + 1);
      end

      // lock keeps req1 for two bytes ahead of a waiting req0
      base = log_req.size();
      src1_q.push_back(mk(8'hA1, 1'b1, 0, 1'b0));
      src1_q.push_back(mk(8'hA2, 1'b0, 0, 1'b0));
      src0_q.push_back(mk(8'h3C, 1'b0, 3, 1'b0));
      wait_drain("drain_lock", 1000);
      chk("lock_count", log_req.size(), base + 3);
      if (log_req.size() >= base + 3) begin
         chk("lock_order0", {log_req[base][7:0], log_dat[base]}, {8'd1, 8'hA1});
         chk("lock_order1", {log_req[base+1][7:0], log_dat[base+1]}, {8'd1, 8'hA2});
         chk("lock_order2", {log_req[base+2][7:0], log_dat[base+2]}, {8'd0, 8'h3C});
      end

      // locked owner without data stalls req0 until lock drops
      base = log_req.size();
      src1_q.push_back(mk(8'h77, 1'b1, 0, 1'b0));
      src1_q.push_back(mk(8'h00, 1'b0, 60, 1'b1));
      src0_q.push_back(mk(8'h88, 1'b0, 3, 1'b0));
      wait_drain("drain_stall", 1000);
      chk("stall_count", log_req.size(), base + 2);
      if (log_req.size() >= base + 2) begin
         chk("stall_first", {log_req[base][7:0], log_dat[base]}, {8'd1, 8'h77});
         chk("stall_second", {log_req[base+1][7:0], log_dat[base+1]}, {8'd0, 8'h88});
         chk("stall_delay", log_cyc[base+1] - log_cyc[base], 61);
      end

      // asynchronous reset in the middle of a data bit
      base = log_req.size();
      src1_q.push_back(mk(8'h00, 1'b0, 0, 1'b0));
      wait_hs("hs_before_reset", base, 200);
      repeat (14) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_tx", bus.uart_tx_o, 1);
      chk("arst_busy", bus.busy_o, 0);
      chk("arst_ready", bus.req_ready_o, 0);
      chk("arst_grant", bus.grant_o, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      src0_q.push_back(mk(8'hC3, 1'b0, 0, 1'b0));
      wait_drain("drain_reset", 500);
      chk("reset_count", log_req.size(), base + 2);
      if (log_req.size() >= base + 2)
         chk("reset_after", {log_req[base+1][7:0], log_dat[base+1]}, {8'd0, 8'hC3});

      // valid/data noise during a frame must not disturb it
      base = log_req.size();
      src0_q.push_back(mk(8'h96, 1'b0, 0, 1'b0));
      wait_hs("hs_before_noise", base, 200);
      noise_en = 1'b1;
      repeat (30) @(posedge clk);
      #2 noise_en = 1'b0;
      wait_drain("drain_noise", 500);
      chk("noise_count", log_req.size(), base + 1);
      if (log_req.size() > base) chk("noise_data", log_dat[base], 8'h96);

      // randomized traffic with locks, gaps and bare lock releases
      base   = log_req.size();
      nbytes = 0;
      for (int n = 0; n < 30; n++) begin
         it = mk(8'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 20),
                 $urandom_range(0, 7) == 0);
         if (!it.nobyte) nbytes++;
         if ($urandom_range(0, 1) == 0) src0_q.push_back(it);
         else                           src1_q.push_back(it);
      end
      src0_q.push_back(mk(8'h00, 1'b0, 0, 1'b1));
      src1_q.push_back(mk(8'h00, 1'b0, 0, 1'b1));
      wait_drain("drain_random", 20000);
      chk("random_count", log_req.size(), base + nbytes);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
